// File: rtl/cpri_tx_pkg_arbiter_if.sv
// cpri_tx_pkg_arbiter_if: requester handshake plus CPRI TX buffer write port
interface cpri_tx_pkg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 64,
    parameter int AW      = 7
);
    logic [NUM_REQ-1:0]    i_req;
    logic [NUM_REQ-1:0]    o_gnt;
    logic [NUM_REQ-1:0]    o_rdy;
    logic [NUM_REQ-1:0]    i_vld;
    logic [NUM_REQ*DW-1:0] i_data;
    logic                  o_cpri_wen;
    logic [AW-1:0]         o_cpri_waddr;
    logic [DW-1:0]         o_cpri_wdata;
    logic                  o_cpri_wlast;

    modport master (
        input  i_req, i_vld, i_data,
        output o_gnt, o_rdy, o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast
    );

    modport slave (
        output i_req, i_vld, i_data,
        input  o_gnt, o_rdy, o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast
    );
endinterface

// File: rtl/cpri_tx_pkg_arbiter.sv
// cpri_tx_pkg_arbiter: round-robin packet scheduler onto a two-bank ping-pong CPRI TX buffer
module cpri_tx_pkg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 64,
    parameter int PKG_LEN = 32,
    parameter int AW      = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_bank_rls,
    cpri_tx_pkg_arbiter_if.master bus,
    output logic                  o_busy,
    output logic                  o_rls_err
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [GW-1:0]      r_last_gnt, w_last_gnt_nxt, w_win_hi, w_win_lo;
    logic               w_any_hi;
    logic [1:0]         r_free_cnt;
    logic               r_wr_bank;
    logic [AW-2:0]      r_beat_cnt;
    logic               r_rls_err;
    logic               r_wen, r_wlast;
    logic [AW-1:0]      r_waddr;
    logic [DW-1:0]      r_wdata, w_data;
    logic               w_start, w_acc, w_last;

    // Lowest requester above last_gnt wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        w_win_hi = '0;
        w_win_lo = '0;
        w_any_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.i_req[i]) begin
                w_win_lo = GW'(i);
                if (GW'(i) > r_last_gnt) begin
                    w_win_hi = GW'(i);
                    w_any_hi = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (r_gnt[i]) w_data = bus.i_data[i*DW +: DW];
    end

    assign w_start = (r_state == IDLE) && i_enable && (r_free_cnt != 2'd0) && (|bus.i_req);
    assign w_acc   = (r_state == XFER) && (|(r_gnt & bus.i_vld));
    assign w_last  = w_acc && (r_beat_cnt == (AW-1)'(PKG_LEN - 1));

    // last_gnt is only consulted in IDLE, so capturing the winner at grant time is equivalent.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_last_gnt_nxt = r_last_gnt;
        if (w_start) begin
            w_state_nxt    = XFER;
            w_last_gnt_nxt = w_any_hi ? w_win_hi : w_win_lo;
            w_gnt_nxt      = NUM_REQ'(1) << w_last_gnt_nxt;
        end else if (w_last) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_last_gnt <= GW'(NUM_REQ - 1);
            r_free_cnt <= 2'd2;
            r_wr_bank  <= 1'b0;
            r_beat_cnt <= '0;
            r_rls_err  <= 1'b0;
            r_wen      <= 1'b0;
            r_wlast    <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            if (w_start)
                r_beat_cnt <= '0;
            else if (w_acc)
                r_beat_cnt <= r_beat_cnt + (AW-1)'(1);
            if (w_last)
                r_wr_bank <= ~r_wr_bank;
            // A release and a consume in the same cycle cancel out.
            if (i_bank_rls && !w_last) begin
                if (r_free_cnt == 2'd2)
                    r_rls_err <= 1'b1;
                else
                    r_free_cnt <= r_free_cnt + 2'd1;
            end else if (w_last && !i_bank_rls) begin
                r_free_cnt <= r_free_cnt - 2'd1;
            end
            r_wen   <= w_acc;
            r_wlast <= w_last;
            if (w_acc) begin
                r_waddr <= {r_wr_bank, r_beat_cnt};
                r_wdata <= w_data;
            end
        end
    end

    assign bus.o_gnt        = r_gnt;
    assign bus.o_rdy        = r_gnt;
    assign bus.o_cpri_wen   = r_wen;
    assign bus.o_cpri_waddr = r_waddr;
    assign bus.o_cpri_wdata = r_wdata;
    assign bus.o_cpri_wlast = r_wlast;
    assign o_busy           = (r_state == XFER);
    assign o_rls_err        = r_rls_err;
endmodule

// File: tb/tb_cpri_tx_pkg_arbiter.sv
// tb_cpri_tx_pkg_arbiter: directed bench for the CPRI TX packet arbiter
module tb_cpri_tx_pkg_arbiter;
    localparam int NR = 4;
    localparam int DW = 64;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst_n, en, rls, busy, rls_err;
    logic [4:0]  src_cnt [NR];
    logic [71:0] wlog [$];
    int n_vec = 0;
    int n_err = 0;

    cpri_tx_pkg_arbiter_if #(.NUM_REQ(NR), .DW(DW), .AW(AW)) bus ();

    cpri_tx_pkg_arbiter #(.NUM_REQ(NR), .DW(DW), .PKG_LEN(32), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enable   (en),
        .i_bank_rls (rls),
        .bus        (bus),
        .o_busy     (busy),
        .o_rls_err  (rls_err)
    );

    always #5 clk = ~clk;

    // Each source presents {k, beat index mod 32} and advances only on an accepted beat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) src_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NR; k++)
                if (bus.o_rdy[k] && bus.i_vld[k]) src_cnt[k] <= src_cnt[k] + 5'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < NR; k++) bus.i_data[k*DW +: DW] = 64'(k * 256) | 64'(src_cnt[k]);
    end

    always @(negedge clk)
        if (bus.o_cpri_wen) wlog.push_back({bus.o_cpri_wlast, bus.o_cpri_waddr, bus.o_cpri_wdata});

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        rls = 1'b1;
        tick();
        rls = 1'b0;
        tick();
    endtask

    // Waits for 32 writes and checks them against requester k at bank base `base`.
    task automatic wait_pkt(input int k, input int base, input bit gaps, input bit rls_last);
        bit [3:0] pat = 4'b1001;
        int cyc = 0;
        logic [71:0] got, exp;
        while (wlog.size() < 32 && cyc < 400) begin
            if (gaps) bus.i_vld[k] = pat[cyc % 4];
            if (rls_last) rls = (src_cnt[k] == 5'd31) && bus.o_rdy[k] && bus.i_vld[k];
            tick();
            cyc++;
        end
        rls = 1'b0;
        chk("pkt_done", 80'(wlog.size() >= 32), 80'(1));
        if (wlog.size() < 32) return;
        for (int j = 0; j < 32; j++) begin
            got = wlog.pop_front();
            exp = {(j == 31), 7'(base + j), 64'(k * 256 + j)};
            chk($sformatf("beat_r%0d_%0d", k, j), 80'(got), 80'(exp));
        end
    endtask

    initial begin
        logic any_last;
        rst_n = 1'b0; en = 1'b0; rls = 1'b0;
        bus.i_req = '0; bus.i_vld = '0;
        repeat (3) tick();
        chk("rst_gnt", 80'(bus.o_gnt), 80'(0));
        chk("rst_wen", 80'(bus.o_cpri_wen), 80'(0));
        chk("rst_waddr", 80'(bus.o_cpri_waddr), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_err", 80'(rls_err), 80'(0));
        rst_n = 1'b1; en = 1'b1;
        tick();
        // single packet, then a second into bank 1
        bus.i_req = 4'b0001; bus.i_vld = 4'b0001;
        tick();
        chk("gnt_req0", 80'(bus.o_gnt), 80'(4'b0001));
        chk("rdy_req0", 80'(bus.o_rdy), 80'(4'b0001));
        chk("busy_xfer", 80'(busy), 80'(1));
        bus.i_req = '0;
        wait_pkt(0, 0, 0, 0);
        bus.i_req = 4'b0001;
        wait_pkt(0, 64, 0, 0);
        // both banks full: no grant until a release
        repeat (20) tick();
        chk("stall_gnt", 80'(bus.o_gnt), 80'(0));
        chk("stall_busy", 80'(busy), 80'(0));
        chk("stall_wen", 80'(wlog.size()), 80'(0));
        rls = 1'b1;
        tick();
        rls = 1'b0;
        tick();
        chk("credit_gnt", 80'(bus.o_gnt), 80'(4'b0001));
        bus.i_req = '0;
        wait_pkt(0, 0, 0, 0);
        // two releases refill; a third is an error
        pulse();
        pulse();
        chk("err_clear", 80'(rls_err), 80'(0));
        pulse();
        chk("err_set", 80'(rls_err), 80'(1));
        repeat (5) tick();
        chk("err_sticky", 80'(rls_err), 80'(1));
        // round robin from reset
        rst_n = 1'b0;
        tick();
        chk("rst2_err", 80'(rls_err), 80'(0));
        rst_n = 1'b1;
        bus.i_req = 4'b1111; bus.i_vld = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_pkt(n % 4, (n % 2) * 64, 0, 0);
            pulse();
            if (n == 3) bus.i_req = '0;
        end
        // release coincident with the last beat leaves credits at 2
        bus.i_req = 4'b0010; bus.i_vld = 4'b0010;
        tick();
        bus.i_req = '0;
        wait_pkt(1, 64, 0, 1);
        chk("sim_err_clear", 80'(rls_err), 80'(0));
        pulse();
        chk("sim_err_set", 80'(rls_err), 80'(1));
        repeat (5) tick();
        chk("sim_err_sticky", 80'(rls_err), 80'(1));
        // valid gaps on req2 while the others assert valid
        bus.i_req = 4'b0100; bus.i_vld = 4'b1011;
        tick();
        bus.i_req = '0;
        wait_pkt(2, 0, 1, 0);
        repeat (5) tick();
        chk("gap_extra", 80'(wlog.size()), 80'(0));
        // enable drops at beat 10
        pulse();
        bus.i_req = 4'b0001; bus.i_vld = 4'b0001;
        tick();
        chk("en_gnt0", 80'(bus.o_gnt), 80'(4'b0001));
        repeat (10) tick();
        en = 1'b0;
        wait_pkt(0, 64, 0, 0);
        repeat (10) tick();
        chk("en_gnt", 80'(bus.o_gnt), 80'(0));
        chk("en_busy", 80'(busy), 80'(0));
        chk("en_wen", 80'(wlog.size()), 80'(0));
        // reset at beat 10
        en = 1'b1;
        tick();
        chk("rstm_gnt0", 80'(bus.o_gnt), 80'(4'b0001));
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("rstm_gnt", 80'(bus.o_gnt), 80'(0));
        chk("rstm_rdy", 80'(bus.o_rdy), 80'(0));
        chk("rstm_wen", 80'(bus.o_cpri_wen), 80'(0));
        chk("rstm_wlast", 80'(bus.o_cpri_wlast), 80'(0));
        chk("rstm_waddr", 80'(bus.o_cpri_waddr), 80'(0));
        chk("rstm_wdata", 80'(bus.o_cpri_wdata), 80'(0));
        chk("rstm_busy", 80'(busy), 80'(0));
        any_last = 1'b0;
        foreach (wlog[i]) any_last |= wlog[i][71];
        chk("rstm_no_wlast", 80'(any_last), 80'(0));
        chk("rstm_partial", 80'(wlog.size() > 0 && wlog.size() < 32), 80'(1));
        wlog.delete();
        tick();
        rst_n = 1'b1;
        bus.i_req = 4'b1111; bus.i_vld = 4'b1111;
        tick();
        chk("post_rst_gnt", 80'(bus.o_gnt), 80'(4'b0001));
        bus.i_req = '0;
        wait_pkt(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
